// File: rtl/mor1kx_refill_arbiter.sv
//------------------------------------------------------------------------------
// mor1kx_refill_arbiter : shares one burst bus between icache and dcache refills
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mor1kx_refill_arbiter #(
  parameter int BLOCK_WIDTH   = 5,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req_i,
  input  logic [31:0] ic_adr_i,
  output logic        ic_ack_o,
  output logic        ic_err_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_adr_i,
  input  logic [31:0] dc_dat_i,
  output logic        dc_ack_o,
  output logic        dc_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic        bus_last_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IC = 2'd1,
    ST_GNT_DC = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [BLOCK_WIDTH-3:0]     beat_cnt_q, beat_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]   wdog_q, wdog_d;
  logic                       last_owner_q, last_owner_d;

  logic                       w_gnt_ic;
  logic                       w_gnt_dc;
  logic                       w_waiting;
  logic [TIMEOUT_WIDTH-1:0]   w_wdog_inc;
  logic                       w_timeout;
  logic                       w_abort;

  assign w_gnt_ic = (state_q == ST_GNT_IC);
  assign w_gnt_dc = (state_q == ST_GNT_DC);

  assign bus_req_o = (w_gnt_ic & ic_req_i) | (w_gnt_dc & dc_req_i);
  assign bus_adr_o = w_gnt_ic ? ic_adr_i : (w_gnt_dc ? dc_adr_i : 32'h0);
  assign bus_we_o  = w_gnt_dc & dc_we_i;
  assign bus_dat_o = w_gnt_dc ? dc_dat_i : 32'h0;
  assign bus_last_o = (&beat_cnt_q) & bus_req_o;
  assign grant_o   = {w_gnt_dc, w_gnt_ic};

  // Timeout fires on the ack-less cycle that would bring the counter to all ones.
  assign w_waiting  = bus_req_o & ~bus_ack_i;
  assign w_wdog_inc = wdog_q + 1'b1;
  assign w_timeout  = w_waiting & (&w_wdog_inc);
  assign w_abort    = (w_gnt_ic | w_gnt_dc) & (bus_err_i | w_timeout);

  assign ic_ack_o = w_gnt_ic & bus_ack_i & ic_req_i & ~w_abort;
  assign dc_ack_o = w_gnt_dc & bus_ack_i & dc_req_i & ~w_abort;
  assign ic_err_o = w_gnt_ic & w_abort;
  assign dc_err_o = w_gnt_dc & w_abort;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      wdog_q       <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      wdog_q       <= wdog_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    wdog_d       = wdog_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (ic_req_i && (!dc_req_i || last_owner_q)) begin
          state_d      = ST_GNT_IC;
          last_owner_d = 1'b0;
        end else if (dc_req_i) begin
          state_d      = ST_GNT_DC;
          last_owner_d = 1'b1;
        end
      end
      ST_GNT_IC, ST_GNT_DC: begin
        // Releasing always passes through IDLE, forcing one dead cycle between owners.
        if (w_abort || !bus_req_o) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          wdog_d     = '0;
        end else if (bus_ack_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          wdog_d     = '0;
        end else begin
          wdog_d     = w_wdog_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_refill_arbiter.sv
//------------------------------------------------------------------------------
// tb_mor1kx_refill_arbiter : directed bench for the icache/dcache refill arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mor1kx_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req_i;
  logic [31:0] ic_adr_i;
  logic        ic_ack_o;
  logic        ic_err_o;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [31:0] dc_adr_i;
  logic [31:0] dc_dat_i;
  logic        dc_ack_o;
  logic        dc_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic        bus_last_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  mor1kx_refill_arbiter #(
    .BLOCK_WIDTH  (5),
    .TIMEOUT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req_i  (ic_req_i),
    .ic_adr_i  (ic_adr_i),
    .ic_ack_o  (ic_ack_o),
    .ic_err_o  (ic_err_o),
    .dc_req_i  (dc_req_i),
    .dc_we_i   (dc_we_i),
    .dc_adr_i  (dc_adr_i),
    .dc_dat_i  (dc_dat_i),
    .dc_ack_o  (dc_ack_o),
    .dc_err_o  (dc_err_o),
    .bus_req_o (bus_req_o),
    .bus_we_o  (bus_we_o),
    .bus_adr_o (bus_adr_o),
    .bus_dat_o (bus_dat_o),
    .bus_last_o(bus_last_o),
    .bus_ack_i (bus_ack_i),
    .bus_err_i (bus_err_i),
    .grant_o   (grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0; ic_req_i = 1'b0; ic_adr_i = '0; dc_req_i = 1'b0; dc_we_i = 1'b0;
    dc_adr_i = '0; dc_dat_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    cyc(); cyc();
    #1;
    chk("reset_grant", 32'(grant_o), 32'h0);
    chk("reset_bus_req", 32'(bus_req_o), 32'h0);
    chk("reset_last", 32'(bus_last_o), 32'h0);
    cyc();
    rst = 1'b1;

    // 1: icache alone, 8-beat refill
    ic_req_i = 1'b1; ic_adr_i = 32'h100;
    #1 chk("t1_grant_latency", 32'(grant_o), 32'h0);
    cyc();
    #1;
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_bus_adr", bus_adr_o, 32'h100);
    for (int i = 0; i < 8; i++) begin
      bus_ack_i = 1'b1; ic_adr_i = 32'h100 + 32'(4 * i);
      #1;
      chk("t1_ic_ack", 32'(ic_ack_o), 32'h1);
      chk("t1_last", 32'(bus_last_o), (i == 7) ? 32'h1 : 32'h0);
      chk("t1_dc_ack", 32'(dc_ack_o), 32'h0);
      cyc();
    end
    bus_ack_i = 1'b0; ic_req_i = 1'b0;
    #1 chk("t1_req_drop", 32'(bus_req_o), 32'h0);
    cyc();
    #1 chk("t1_idle", 32'(grant_o), 32'h0);

    // 2: contention after reset -> icache first
    rst = 1'b0;
    cyc();
    rst = 1'b1; ic_req_i = 1'b1; dc_req_i = 1'b1; ic_adr_i = 32'h300; dc_adr_i = 32'h2000;
    cyc();
    #1;
    chk("t2_grant_ic", 32'(grant_o), 32'h1);
    chk("t2_bus_adr", bus_adr_o, 32'h300);
    bus_ack_i = 1'b1;
    #1;
    chk("t2_ic_ack", 32'(ic_ack_o), 32'h1);
    chk("t2_dc_ack", 32'(dc_ack_o), 32'h0);
    cyc();
    bus_ack_i = 1'b0; ic_req_i = 1'b0;
    cyc();
    #1 chk("t2_idle_gap", 32'(grant_o), 32'h0);
    cyc();
    #1 chk("t2_grant_dc", 32'(grant_o), 32'h2);

    // 3: dcache write
    dc_we_i = 1'b1; dc_adr_i = 32'h1000; dc_dat_i = 32'hDEADBEEF; ic_req_i = 1'b1;
    #1;
    chk("t3_we", 32'(bus_we_o), 32'h1);
    chk("t3_adr", bus_adr_o, 32'h1000);
    chk("t3_dat", bus_dat_o, 32'hDEADBEEF);
    chk("t3_dc_ack_idle", 32'(dc_ack_o), 32'h0);
    bus_ack_i = 1'b1;
    #1;
    chk("t3_dc_ack", 32'(dc_ack_o), 32'h1);
    chk("t3_ic_ack", 32'(ic_ack_o), 32'h0);
    cyc();
    bus_ack_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0;
    #1 chk("t3_we_off", 32'(bus_we_o), 32'h0);
    cyc();
    #1 chk("t3_idle", 32'(grant_o), 32'h0);
    cyc();
    #1 chk("t3_grant_ic", 32'(grant_o), 32'h1);

    // 4: bus error on beat 3 of an icache refill
    bus_ack_i = 1'b1;
    cyc();
    cyc();
    bus_err_i = 1'b1;
    #1;
    chk("t4_ic_err", 32'(ic_err_o), 32'h1);
    chk("t4_ic_ack_suppressed", 32'(ic_ack_o), 32'h0);
    cyc();
    bus_err_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("t4_idle", 32'(grant_o), 32'h0);
    chk("t4_err_clear", 32'(ic_err_o), 32'h0);
    cyc();
    #1 chk("t4_regrant", 32'(grant_o), 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_ack_i = 1'b1;
      #1 chk("t4_last", 32'(bus_last_o), (i == 7) ? 32'h1 : 32'h0);
      cyc();
    end
    bus_ack_i = 1'b0; ic_req_i = 1'b0;
    cyc();

    // 5: watchdog with TIMEOUT_WIDTH=4
    ic_req_i = 1'b1;
    cyc();
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("t5_ic_err", 32'(ic_err_o), (k == 15) ? 32'h1 : 32'h0);
      if (k < 15) chk("t5_grant_held", 32'(grant_o), 32'h1);
      cyc();
    end
    #1 chk("t5_grant_dropped", 32'(grant_o), 32'h0);
    ic_req_i = 1'b0;
    bus_err_i = 1'b1;
    #1 chk("t5_err_ignored_idle", 32'(ic_err_o), 32'h0);
    bus_err_i = 1'b0;
    cyc();

    // 6: reset mid dcache burst, then contention
    dc_req_i = 1'b1; dc_adr_i = 32'h4000;
    cyc();
    #1 chk("t6_grant_dc", 32'(grant_o), 32'h2);
    bus_ack_i = 1'b1;
    cyc();
    bus_ack_i = 1'b0; rst = 1'b0;
    cyc();
    #1 chk("t6_reset_drop", 32'(grant_o), 32'h0);
    rst = 1'b1; ic_req_i = 1'b1;
    cyc();
    #1 chk("t6_ic_wins", 32'(grant_o), 32'h1);
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
